// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// State encodings, fetch-entry layout and the PC alignment helper.
package ifu_fetch_pkg;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned INSTR_W = 32;

   localparam logic [XLEN-1:0]    PC_INCR   = 32'd4;
   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      IFU_RUN   = 2'd0,
      IFU_FLUSH = 2'd1,
      IFU_HALT  = 2'd2
   } ifu_state_e;

   typedef struct packed {
      logic [XLEN-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
      return {pc[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous instruction buffer holding {pc, instr} entries.
// Clear wins over push/pop; DEPTH must be a power of two so pointers wrap naturally.
module ifu_fifo
   import ifu_fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           clear,
   input  logic                           push,
   input  fetch_entry_t                   wdata,
   input  logic                           pop,
   output fetch_entry_t                   rdata,
   output logic [$clog2(DEPTH + 1)-1:0]   count,
   output logic                           empty,
   output logic                           full
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   fetch_entry_t  mem_q [DEPTH];
   logic [PW-1:0] rd_ptr_q;
   logic [PW-1:0] wr_ptr_q;
   logic [CW-1:0] count_q;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign count   = count_q;
   assign do_pop  = pop && !empty;
   // A full buffer can still accept a push when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         if (do_push && !do_pop) begin
            count_q <= count_q + CW'(1);
         end else if (!do_push && do_pop) begin
            count_q <= count_q - CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !clear && !rst) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   assert property (@(posedge clk) disable iff (rst) !(push && full && !pop))
      else $error("ifu_fifo: push into full buffer");

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: owns the PC, issues credit-limited requests, buffers responses.
// Optional misaligned-redirect trap with HALT state is enabled by IFU_MISALIGN_TRAP_EN.
module ifu_fetch
   import ifu_fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned     FIFO_DEPTH = 2
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req,
   output logic [XLEN-1:0]    imem_addr,
   input  logic               imem_gnt,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               redirect_valid,
   input  logic [XLEN-1:0]    redirect_pc,
   output logic               id_valid,
   output logic [INSTR_W-1:0] id_instr,
   output logic [XLEN-1:0]    id_pc,
   input  logic               id_ready
`ifdef IFU_MISALIGN_TRAP_EN
   ,
   output logic               id_misalign
`endif
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned SW = CW + 1;
   localparam logic [SW-1:0] CREDITS = SW'(FIFO_DEPTH);

   ifu_state_e      state_q;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] resp_pc_q;
   logic [CW-1:0]   outst_q;
   logic [CW-1:0]   outst_d;
   logic [CW-1:0]   fifo_count;
   logic [SW-1:0]   credit_used;
   logic            fifo_empty;
   logic            fifo_full;
   logic            grant;
   logic            rsp;
   logic            push;
   logic            pop;
   logic [XLEN-1:0] redirect_tgt;
   fetch_entry_t    push_entry;
   fetch_entry_t    head_entry;

`ifdef IFU_MISALIGN_TRAP_EN
   logic halt_pend_q;
   logic misalign;
   assign misalign    = (redirect_pc[1:0] != 2'b00);
   assign id_misalign = (state_q == IFU_HALT);
`endif

   assign redirect_tgt = align_pc(redirect_pc);
   assign credit_used  = SW'(outst_q) + SW'(fifo_count);

   // Buffered plus in-flight words never exceed the buffer, so a response always has room.
   assign imem_req  = !rst && (state_q == IFU_RUN) && !redirect_valid && (credit_used < CREDITS);
   assign imem_addr = pc_q;
   assign grant     = imem_req && imem_gnt;
   assign rsp       = imem_rvalid && (outst_q != '0);
   assign push      = rsp && (state_q == IFU_RUN) && !redirect_valid;
   assign pop       = id_valid && id_ready && !redirect_valid;

   assign push_entry = '{pc: resp_pc_q, instr: imem_rdata};
   assign id_valid   = !rst && !fifo_empty;
   assign id_pc      = head_entry.pc;
   assign id_instr   = head_entry.instr;

   always_comb begin
      outst_d = outst_q;
      if (grant && !rsp) begin
         outst_d = outst_q + CW'(1);
      end else if (!grant && rsp) begin
         outst_d = outst_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IFU_RUN;
         pc_q      <= RESET_PC;
         resp_pc_q <= RESET_PC;
         outst_q   <= '0;
`ifdef IFU_MISALIGN_TRAP_EN
         halt_pend_q <= 1'b0;
`endif
      end else begin
         outst_q <= outst_d;
         if (redirect_valid) begin
            pc_q      <= redirect_tgt;
            resp_pc_q <= redirect_tgt;
`ifdef IFU_MISALIGN_TRAP_EN
            halt_pend_q <= misalign;
            if (outst_d != '0) begin
               state_q <= IFU_FLUSH;
            end else if (misalign) begin
               state_q <= IFU_HALT;
            end else begin
               state_q <= IFU_RUN;
            end
`else
            state_q <= (outst_d != '0) ? IFU_FLUSH : IFU_RUN;
`endif
         end else begin
            if (grant) pc_q <= pc_q + PC_INCR;
            if (push)  resp_pc_q <= resp_pc_q + PC_INCR;
            // Leave FLUSH in the same cycle the last stale response is dropped.
            if (state_q == IFU_FLUSH && outst_d == '0) begin
`ifdef IFU_MISALIGN_TRAP_EN
               state_q <= halt_pend_q ? IFU_HALT : IFU_RUN;
`else
               state_q <= IFU_RUN;
`endif
            end
         end
      end
   end

   ifu_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clear (redirect_valid),
      .push  (push),
      .wdata (push_entry),
      .pop   (pop),
      .rdata (head_entry),
      .count (fifo_count),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   assert property (@(posedge clk) disable iff (rst) credit_used <= CREDITS)
      else $error("ifu_fetch: credit overrun");

   assert property (@(posedge clk) disable iff (rst) !(push && fifo_full && !pop))
      else $error("ifu_fetch: response pushed into full buffer");

endmodule
